hazard_ctrl_v2: RTL and testbench
=================================

// Module: hazard_ctrl_v2
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage core (IF/DEC/EXE/MEM/WB).
//  Selects EXE operand bypass, detects load-use, and sequences multi-cycle load-use stalls and post-redirect flush windows with an FSM.
//  Merges I$/D$ stalls into per-register enable/kill vectors and keeps saturating stall/flush perf counters.
//  Sits beside the pipeline registers; drives their enb/kill pins, pc stop and EXE nop injection.
// PARAMETERS
//  RA_W        5   register address width (x0 = all zeros, never forwarded/stalled on)
//  LD_USE_CYC  1   load-use stall cycles, 1..7
//  FLUSH_CYC   1   IF/DEC kill cycles after a redirect (fetch latency), 1..7
//  CNT_W       32  width of perf counters
// PORTS
//  clk           in   1     core clock
//  rst_n         in   1     asynchronous active-low reset
//  dec_valid     in   1     DEC holds a valid instruction
//  dec_rs1/rs2   in   RA_W  DEC source registers
//  exe_valid     in   1     EXE holds a valid instruction
//  exe_rs1/rs2   in   RA_W  EXE source registers
//  exe_rd        in   RA_W  EXE destination
//  exe_we        in   1     EXE writes register file
//  exe_is_load   in   1     EXE instruction is a load
//  exe_redirect  in   1     EXE branch taken / jump resolved (PC redirect)
//  mem_rd,wb_rd  in   RA_W  MEM / WB destinations
//  mem_we,wb_we  in   1     MEM / WB register-file write enables (qualified by valid)
//  icache_stall  in   1     fetch miss
//  dcache_stall  in   1     data miss, freezes whole pipe
//  cnt_clr       in   1     synchronous clear of perf counters
//  stage_enb     out  4     enable per pipe reg: [0]IF/DEC [1]DEC/EXE [2]EXE/MEM [3]MEM/WB
//  stage_kill    out  4     kill (load bubble) per pipe reg, same mapping
//  pc_stop       out  1     hold PC
//  nop_gen       out  1     inject bubble into DEC/EXE
//  fwd_rs1_sel   out  2     EXE src1 mux: 00 regfile, 01 MEM, 10 WB
//  fwd_rs2_sel   out  2     EXE src2 mux, same encoding
//  fsm_state     out  2     00 RUN, 01 LDSTALL, 10 FLUSH (debug)
//  stall_cnt     out  CNT_W cycles with pc_stop=1 (saturating)
//  flush_cnt     out  CNT_W accepted redirects (saturating)
// BEHAVIOUR
//  Reset (rst_n=0, async): state RUN, internal count 0, counters 0; outputs forced stage_enb=4'hF, stage_kill=4'hF, pc_stop=1, nop_gen=0, fwd sel=00.
//  Forwarding (comb, 0 latency): src==mem_rd & mem_we & src!=0 -> 01; else src==wb_rd & wb_we & src!=0 -> 10; else 00. MEM wins over WB.
//  Default RUN outputs: enb=4'hF, kill=0, pc_stop=0, nop_gen=0.
//  load_use = exe_valid & exe_is_load & exe_we & exe_rd!=0 & dec_valid & (dec_rs1==exe_rd | dec_rs2==exe_rd).
//  redir = exe_valid & exe_redirect & !dcache_stall.
//  RUN: redir -> kill[1:0]=11, flush_cnt++; FLUSH_CYC>1 -> FLUSH, cnt=FLUSH_CYC-1.
//       else load_use -> enb[0]=0, pc_stop=1, nop_gen=1; LD_USE_CYC>1 -> LDSTALL, cnt=LD_USE_CYC-1.
//  LDSTALL: enb[0]=0, pc_stop=1, nop_gen=1; cnt--; cnt==1 -> RUN next cycle.
//  FLUSH: kill[0]=1; cnt--; cnt==1 -> RUN. redir here (EXE already killed) cannot occur; if seen, treat as in RUN.
//  icache_stall (any state): OR-in enb[0]=0, pc_stop=1, nop_gen=1; FSM still advances.
//  dcache_stall: enb=4'h0, kill=0, nop_gen=0, pc_stop=1; FSM state/cnt hold; redirect and load_use not acted on (EXE frozen, re-evaluated after).
//  Counters: stall_cnt +1 per cycle with pc_stop=1; saturate at all-ones; cnt_clr zeroes both (clr wins over increment).
//  Widths: all compares full RA_W; internal cnt 3 bits.
// TESTING
//  rst_n 0->1 -> enb=F kill=F pc_stop=1 during reset; first cycle after: enb=F kill=0 state RUN, counters 0.
//  exe_rs1=5,mem_rd=5,mem_we=1,wb_rd=5,wb_we=1 -> fwd_rs1_sel=01; exe_rs1=0 with mem_rd=0 -> 00.
//  LD_USE_CYC=3, load x7 in EXE, dec_rs2=7 -> 3 cycles enb[0]=0,nop_gen=1, then RUN; stall_cnt=3.
//  FLUSH_CYC=2, exe_redirect=1 -> cycle0 kill=0011, cycle1 kill=0001, cycle2 kill=0; flush_cnt=1.
//  redirect + dcache_stall for 4 cycles -> enb=0, no kill, flush_cnt=0; stall drops -> kill=0011, flush_cnt=1.
//  CNT_W=4, hold icache_stall 20 cycles -> stall_cnt=15 saturated; cnt_clr -> 0; async reset mid-LDSTALL -> RUN.

Source files
------------

// File: rtl/hazard_ctrl_v2.sv
// ============================================================================
// hazard_ctrl_v2
// Hazard and forwarding controller for the 5-stage core (IF/DEC/EXE/MEM/WB).
//  - Selects the EXE operand bypass source (MEM beats WB, x0 never bypassed).
//  - Detects load-use hazards and holds IF/DEC for LD_USE_CYC cycles while
//    feeding bubbles into EXE.
//  - Kills IF/DEC (and DEC/EXE on the redirect cycle) for FLUSH_CYC cycles
//    after a PC redirect resolved in EXE.
//  - Merges I$ and D$ miss stalls into the per-register enable/kill vectors.
//  - Keeps saturating perf counters of stalled cycles and accepted redirects.
//
// Ports
//  clk, rst_n                 core clock, asynchronous active-low reset
//  dec_valid, dec_rs1/rs2     DEC slot contents
//  exe_valid, exe_rs1/rs2     EXE slot sources
//  exe_rd, exe_we, exe_is_load, exe_redirect   EXE slot destination/type
//  mem_rd/mem_we, wb_rd/wb_we later-stage writers (bypass sources)
//  icache_stall, dcache_stall cache miss stalls
//  cnt_clr                    synchronous clear of both perf counters
//  stage_enb/stage_kill [3:0] per pipe register: [0]IF/DEC [1]DEC/EXE
//                             [2]EXE/MEM [3]MEM/WB
//  pc_stop, nop_gen           hold PC / inject bubble into DEC/EXE
//  fwd_rs1_sel/fwd_rs2_sel    00 regfile, 01 MEM, 10 WB
//  fsm_state                  00 RUN, 01 LDSTALL, 10 FLUSH
//  stall_cnt, flush_cnt       saturating perf counters
// ============================================================================
module hazard_ctrl_v2 #(
    parameter int RA_W       = 5,
    parameter int LD_USE_CYC = 1,
    parameter int FLUSH_CYC  = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [RA_W-1:0]  dec_rs1,
    input  logic [RA_W-1:0]  dec_rs2,
    input  logic             exe_valid,
    input  logic [RA_W-1:0]  exe_rs1,
    input  logic [RA_W-1:0]  exe_rs2,
    input  logic [RA_W-1:0]  exe_rd,
    input  logic             exe_we,
    input  logic             exe_is_load,
    input  logic             exe_redirect,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_we,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_we,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             cnt_clr,
    output logic [3:0]       stage_enb,
    output logic [3:0]       stage_kill,
    output logic             pc_stop,
    output logic             nop_gen,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [1:0]       fsm_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_FLUSH   = 2'b10
    } state_t;

    // The state counter reloads with cycles remaining after the entry cycle.
    localparam logic [2:0] LD_RELOAD = 3'(LD_USE_CYC - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYC - 1);
    localparam logic [RA_W-1:0] X0 = '0;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] enb_int, kill_int;
    logic       pc_stop_int, nop_int, flush_inc;
    logic       load_use, redir;

    // Bypass priority: the younger MEM result shadows the older WB result.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                           input logic [RA_W-1:0] m_rd,
                                           input logic            m_we,
                                           input logic [RA_W-1:0] w_rd,
                                           input logic            w_we);
        if (src != X0 && m_we && src == m_rd)
            return 2'b01;
        else if (src != X0 && w_we && src == w_rd)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = exe_valid && exe_is_load && exe_we && (exe_rd != X0) &&
                      dec_valid && ((dec_rs1 == exe_rd) || (dec_rs2 == exe_rd));
    assign redir    = exe_valid && exe_redirect && !dcache_stall;

    // Next-state and pipeline control. A D$ miss freezes everything, so it
    // overrides both the FSM and the I$ stall contribution.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enb_int     = 4'hF;
        kill_int    = 4'h0;
        pc_stop_int = 1'b0;
        nop_int     = 1'b0;
        flush_inc   = 1'b0;

        if (dcache_stall) begin
            enb_int     = 4'h0;
            pc_stop_int = 1'b1;
        end else begin
            if (state_q == ST_LDSTALL) begin
                enb_int[0]  = 1'b0;
                pc_stop_int = 1'b1;
                nop_int     = 1'b1;
                cnt_d       = cnt_q - 3'd1;
                if (cnt_q == 3'd1)
                    state_d = ST_RUN;
            end else if (redir) begin
                // Handled identically from RUN or FLUSH: restart the window.
                kill_int[1:0] = 2'b11;
                flush_inc     = 1'b1;
                if (FLUSH_CYC > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = FL_RELOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end else if (state_q == ST_FLUSH) begin
                kill_int[0] = 1'b1;
                cnt_d       = cnt_q - 3'd1;
                if (cnt_q == 3'd1)
                    state_d = ST_RUN;
            end else if (load_use) begin
                enb_int[0]  = 1'b0;
                pc_stop_int = 1'b1;
                nop_int     = 1'b1;
                if (LD_USE_CYC > 1) begin
                    state_d = ST_LDSTALL;
                    cnt_d   = LD_RELOAD;
                end
            end

            if (icache_stall) begin
                enb_int[0]  = 1'b0;
                pc_stop_int = 1'b1;
                nop_int     = 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Saturating perf counters; a clear request beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stop_int && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    // While reset is asserted every pipe register is enabled and killed so
    // the pipeline fills with bubbles, and the PC is held.
    assign stage_enb   = rst_n ? enb_int     : 4'hF;
    assign stage_kill  = rst_n ? kill_int    : 4'hF;
    assign pc_stop     = rst_n ? pc_stop_int : 1'b1;
    assign nop_gen     = rst_n ? nop_int     : 1'b0;
    assign fwd_rs1_sel = rst_n ? fwd_sel(exe_rs1, mem_rd, mem_we, wb_rd, wb_we) : 2'b00;
    assign fwd_rs2_sel = rst_n ? fwd_sel(exe_rs2, mem_rd, mem_we, wb_rd, wb_we) : 2'b00;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// ============================================================================
// tb_hazard_ctrl_v2
// Self-checking bench for hazard_ctrl_v2 built with LD_USE_CYC=3, FLUSH_CYC=2,
// CNT_W=4. Directed steps cover reset, forwarding, load-use, flush, D$ freeze,
// counter saturation/clear and async reset; a random phase follows. Expected
// values come from a reference model that tracks remaining stall/flush cycles
// and perf counts as plain integers.
// ============================================================================
module tb_hazard_ctrl_v2;

    localparam int RA_W       = 5;
    localparam int LD_USE_CYC = 3;
    localparam int FLUSH_CYC  = 2;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            dec_valid;
    logic [RA_W-1:0] dec_rs1, dec_rs2;
    logic            exe_valid;
    logic [RA_W-1:0] exe_rs1, exe_rs2, exe_rd;
    logic            exe_we, exe_is_load, exe_redirect;
    logic [RA_W-1:0] mem_rd, wb_rd;
    logic            mem_we, wb_we;
    logic            icache_stall, dcache_stall, cnt_clr;
    logic [3:0]      stage_enb, stage_kill;
    logic            pc_stop, nop_gen;
    logic [1:0]      fwd_rs1_sel, fwd_rs2_sel, fsm_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Reference model: cycles still to stall / still to kill, and perf counts.
    int m_ld_rem = 0;
    int m_fl_rem = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    hazard_ctrl_v2 #(
        .RA_W(RA_W), .LD_USE_CYC(LD_USE_CYC), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .exe_valid(exe_valid), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2),
        .exe_rd(exe_rd), .exe_we(exe_we), .exe_is_load(exe_is_load),
        .exe_redirect(exe_redirect),
        .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd), .wb_we(wb_we),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall), .cnt_clr(cnt_clr),
        .stage_enb(stage_enb), .stage_kill(stage_kill),
        .pc_stop(pc_stop), .nop_gen(nop_gen),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .fsm_state(fsm_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive every input to its quiet value.
    task automatic applyStimulus();
        dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0;
        exe_valid = 1'b0; exe_rs1 = '0; exe_rs2 = '0; exe_rd = '0;
        exe_we = 1'b0; exe_is_load = 1'b0; exe_redirect = 1'b0;
        mem_rd = '0; mem_we = 1'b0; wb_rd = '0; wb_we = 1'b0;
        icache_stall = 1'b0; dcache_stall = 1'b0; cnt_clr = 1'b0;
    endtask

    function automatic logic [1:0] expFwd(input logic [RA_W-1:0] src);
        if (src != 0 && mem_we && src == mem_rd) return 2'b01;
        if (src != 0 && wb_we && src == wb_rd)   return 2'b10;
        return 2'b00;
    endfunction

    // Check the current cycle against the model, then advance the model
    // across the following rising edge.
    task automatic checkCycle(input string tag);
        logic [3:0] e_enb, e_kill;
        logic       e_pc, e_nop, lu, redir;
        logic [1:0] e_state;
        int         n_ld, n_fl, inc_fl;
        #1;
        e_enb = 4'hF; e_kill = 4'h0; e_pc = 1'b0; e_nop = 1'b0;
        e_state = (m_ld_rem > 0) ? 2'b01 : (m_fl_rem > 0) ? 2'b10 : 2'b00;
        n_ld = m_ld_rem; n_fl = m_fl_rem; inc_fl = 0;
        redir = exe_valid && exe_redirect;
        lu = exe_valid && exe_is_load && exe_we && exe_rd != 0 && dec_valid &&
             (dec_rs1 == exe_rd || dec_rs2 == exe_rd);
        if (dcache_stall) begin
            e_enb = 4'h0; e_pc = 1'b1;
        end else begin
            if (m_ld_rem > 0) begin
                e_enb[0] = 1'b0; e_pc = 1'b1; e_nop = 1'b1; n_ld = m_ld_rem - 1;
            end else if (redir) begin
                e_kill = 4'h3; inc_fl = 1; n_fl = FLUSH_CYC - 1;
            end else if (m_fl_rem > 0) begin
                e_kill = 4'h1; n_fl = m_fl_rem - 1;
            end else if (lu) begin
                e_enb[0] = 1'b0; e_pc = 1'b1; e_nop = 1'b1; n_ld = LD_USE_CYC - 1;
            end
            if (icache_stall) begin
                e_enb[0] = 1'b0; e_pc = 1'b1; e_nop = 1'b1;
            end
        end
        checkOutput({tag, ".enb"},   32'(stage_enb),   32'(e_enb));
        checkOutput({tag, ".kill"},  32'(stage_kill),  32'(e_kill));
        checkOutput({tag, ".pc"},    32'(pc_stop),     32'(e_pc));
        checkOutput({tag, ".nop"},   32'(nop_gen),     32'(e_nop));
        checkOutput({tag, ".state"}, 32'(fsm_state),   32'(e_state));
        checkOutput({tag, ".fwd1"},  32'(fwd_rs1_sel), 32'(expFwd(exe_rs1)));
        checkOutput({tag, ".fwd2"},  32'(fwd_rs2_sel), 32'(expFwd(exe_rs2)));
        checkOutput({tag, ".scnt"},  32'(stall_cnt),   32'(m_stall));
        checkOutput({tag, ".fcnt"},  32'(flush_cnt),   32'(m_flush));
        @(posedge clk);
        m_ld_rem = n_ld;
        m_fl_rem = n_fl;
        if (cnt_clr) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (e_pc && m_stall < CNT_MAX)     m_stall++;
            if (inc_fl == 1 && m_flush < CNT_MAX) m_flush++;
        end
    endtask

    task automatic modelReset();
        m_ld_rem = 0; m_fl_rem = 0; m_stall = 0; m_flush = 0;
    endtask

    initial begin
        // Reset: outputs forced even with bypass-matching inputs.
        applyStimulus();
        rst_n = 1'b0;
        mem_rd = 5'd5; mem_we = 1'b1; exe_rs1 = 5'd5;
        #2;
        checkOutput("rst.enb",  32'(stage_enb),   32'hF);
        checkOutput("rst.kill", 32'(stage_kill),  32'hF);
        checkOutput("rst.pc",   32'(pc_stop),     32'h1);
        checkOutput("rst.nop",  32'(nop_gen),     32'h0);
        checkOutput("rst.fwd1", 32'(fwd_rs1_sel), 32'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
        #1;
        checkOutput("post.enb",   32'(stage_enb),  32'hF);
        checkOutput("post.kill",  32'(stage_kill), 32'h0);
        checkOutput("post.state", 32'(fsm_state),  32'h0);
        checkOutput("post.scnt",  32'(stall_cnt),  32'h0);
        checkCycle("post");

        // Forwarding.
        @(negedge clk);
        applyStimulus();
        exe_rs1 = 5'd5; mem_rd = 5'd5; mem_we = 1'b1; wb_rd = 5'd5; wb_we = 1'b1;
        exe_rs2 = 5'd9; 
        #1;
        checkOutput("fwd.mem", 32'(fwd_rs1_sel), 32'h1);
        checkCycle("fwd.a");
        @(negedge clk);
        applyStimulus();
        exe_rs1 = 5'd0; mem_rd = 5'd0; mem_we = 1'b1; exe_rs2 = 5'd3; wb_rd = 5'd3; wb_we = 1'b1;
        #1;
        checkOutput("fwd.x0", 32'(fwd_rs1_sel), 32'h0);
        checkOutput("fwd.wb", 32'(fwd_rs2_sel), 32'h2);
        checkCycle("fwd.b");

        // Load-use: three stall cycles, then RUN with stall_cnt=3.
        @(negedge clk);
        applyStimulus();
        cnt_clr = 1'b1;
        checkCycle("ld.clr");
        @(negedge clk);
        applyStimulus();
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_we = 1'b1; exe_rd = 5'd7;
        dec_valid = 1'b1; dec_rs2 = 5'd7;
        #1;
        checkOutput("ld.c0.nop", 32'(nop_gen), 32'h1);
        checkCycle("ld.c0");
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            applyStimulus();
            #1;
            checkOutput("ld.cN.enb", 32'(stage_enb), 32'hE);
            checkCycle("ld.cN");
        end
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput("ld.done.state", 32'(fsm_state), 32'h0);
        checkOutput("ld.done.scnt",  32'(stall_cnt), 32'h3);
        checkCycle("ld.done");

        // Redirect: kill 0011, 0001, 0000; flush_cnt=1.
        @(negedge clk);
        applyStimulus();
        cnt_clr = 1'b1;
        checkCycle("fl.clr");
        @(negedge clk);
        applyStimulus();
        exe_valid = 1'b1; exe_redirect = 1'b1;
        #1;
        checkOutput("fl.c0", 32'(stage_kill), 32'h3);
        checkCycle("fl.c0");
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput("fl.c1", 32'(stage_kill), 32'h1);
        checkCycle("fl.c1");
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput("fl.c2",   32'(stage_kill), 32'h0);
        checkOutput("fl.fcnt", 32'(flush_cnt),  32'h1);
        checkCycle("fl.c2");

        // Redirect held under a D$ miss is deferred until the miss clears.
        @(negedge clk);
        applyStimulus();
        cnt_clr = 1'b1;
        checkCycle("dc.clr");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus();
            exe_valid = 1'b1; exe_redirect = 1'b1; dcache_stall = 1'b1;
            #1;
            checkOutput("dc.enb",  32'(stage_enb),  32'h0);
            checkOutput("dc.kill", 32'(stage_kill), 32'h0);
            checkCycle("dc.hold");
        end
        @(negedge clk);
        applyStimulus();
        exe_valid = 1'b1; exe_redirect = 1'b1;
        #1;
        checkOutput("dc.fcnt0", 32'(flush_cnt),  32'h0);
        checkOutput("dc.kill1", 32'(stage_kill), 32'h3);
        checkCycle("dc.go");
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput("dc.fcnt1", 32'(flush_cnt), 32'h1);
        checkCycle("dc.tail");

        // I$ stall saturates the 4-bit stall counter, then clear.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus();
            icache_stall = 1'b1;
            checkCycle("ic.hold");
        end
        @(negedge clk);
        applyStimulus();
        cnt_clr = 1'b1;
        #1;
        checkOutput("ic.sat", 32'(stall_cnt), 32'hF);
        checkCycle("ic.clr");
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput("ic.zero", 32'(stall_cnt), 32'h0);
        checkCycle("ic.after");

        // Async reset in the middle of a load-use stall.
        @(negedge clk);
        applyStimulus();
        exe_valid = 1'b1; exe_is_load = 1'b1; exe_we = 1'b1; exe_rd = 5'd4;
        dec_valid = 1'b1; dec_rs1 = 5'd4;
        checkCycle("ar.enter");
        @(negedge clk);
        applyStimulus();
        #2;
        checkOutput("ar.pre", 32'(fsm_state), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("ar.state", 32'(fsm_state),  32'h0);
        checkOutput("ar.kill",  32'(stage_kill), 32'hF);
        checkOutput("ar.scnt",  32'(stall_cnt),  32'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        checkCycle("ar.run");

        // Random phase against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            dec_valid    = ($urandom_range(0, 9) != 0);
            dec_rs1      = RA_W'($urandom_range(0, 3));
            dec_rs2      = RA_W'($urandom_range(0, 3));
            exe_valid    = ($urandom_range(0, 9) != 0);
            exe_rs1      = RA_W'($urandom_range(0, 3));
            exe_rs2      = RA_W'($urandom_range(0, 3));
            exe_rd       = RA_W'($urandom_range(0, 3));
            exe_we       = ($urandom_range(0, 3) != 0);
            exe_is_load  = ($urandom_range(0, 2) == 0);
            exe_redirect = ($urandom_range(0, 9) == 0);
            mem_rd       = RA_W'($urandom_range(0, 3));
            mem_we       = $urandom_range(0, 1) == 1;
            wb_rd        = RA_W'($urandom_range(0, 3));
            wb_we        = $urandom_range(0, 1) == 1;
            icache_stall = ($urandom_range(0, 6) == 0);
            dcache_stall = ($urandom_range(0, 6) == 0);
            cnt_clr      = ($urandom_range(0, 40) == 0);
            checkCycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
